// File: rtl/mdu_stall_ctrl.sv
// Stall and sequencing controller for the multi-cycle multiply/divide unit.
// It holds D-stage HI/LO consumers until the result commits and merges in load-use stalls.
module mdu_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             d_uses_mdu_i,
  input  logic             load_use_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             pc_en_o,
  output logic             d_en_o,
  output logic             e_flush_o,
  output logic             hilo_we_o,
  output logic [CNT_W-1:0] cycles_left_o,
  output logic             protocol_err_o,
  output logic [15:0]      stall_cycles_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perr_q, perr_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] load_val;

  // is_div is only meaningful while start is high, so it is only used to pick the reload value.
  assign load_val = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    perr_d    = perr_q;
    hilo_we_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = load_val;
        end
      end
      RUN: begin
        if (start_i) perr_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        hilo_we_o = 1'b1;
        if (start_i) begin
          state_d = RUN;
          cnt_d   = load_val;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o         = (state_q == RUN) | start_i;
  assign stall_o        = (busy_o & d_uses_mdu_i) | load_use_i;
  assign pc_en_o        = ~stall_o;
  assign d_en_o         = ~stall_o;
  assign e_flush_o      = stall_o;
  assign cycles_left_o  = (state_q == RUN) ? cnt_q : '0;
  assign protocol_err_o = perr_q;
  assign stall_cycles_o = stall_cnt_q;

  // The counter saturates rather than wrapping so long runs still read as "at least this many".
  assign stall_cnt_d = (stall_o && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      perr_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      perr_q      <= perr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// Directed bench for mdu_stall_ctrl: reset, mult/div sequencing, illegal restart,
// load-use merge and stall counter saturation, all against hand-computed values.
module tb_mdu_stall_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start, is_div, d_uses_mdu, load_use;
  logic             busy, stall, pc_en, d_en, e_flush, hilo_we, protocol_err;
  logic [CNT_W-1:0] cycles_left;
  logic [15:0]      stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  mdu_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .start_i        (start),
    .is_div_i       (is_div),
    .d_uses_mdu_i   (d_uses_mdu),
    .load_use_i     (load_use),
    .busy_o         (busy),
    .stall_o        (stall),
    .pc_en_o        (pc_en),
    .d_en_o         (d_en),
    .e_flush_o      (e_flush),
    .hilo_we_o      (hilo_we),
    .cycles_left_o  (cycles_left),
    .protocol_err_o (protocol_err),
    .stall_cycles_o (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs change 1 ns after the edge and are checked 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    settle();
    reset_n = 1'b1;
    step();
  endtask

  int we_seen;

  initial begin
    reset_n = 1'b0; start = 0; is_div = 0; d_uses_mdu = 0; load_use = 0;
    #12;
    // Reset state
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_pc_en", pc_en, 1);
    check("rst_hilo_we", hilo_we, 0);
    check("rst_cycles_left", cycles_left, 0);
    check("rst_perr", protocol_err, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    start = 1; d_uses_mdu = 1; settle();
    check("rst_busy_from_start", busy, 1);
    check("rst_stall_from_start", stall, 1);
    start = 0; d_uses_mdu = 0;
    reset_n = 1'b1;
    step();

    // Mult with defaults, D consumer held
    start = 1; is_div = 0; d_uses_mdu = 1; settle();
    check("mul_busy_t", busy, 1);
    check("mul_stall_t", stall, 1);
    step(); start = 0; settle();
    for (int k = 5; k >= 1; k--) begin
      check($sformatf("mul_cl_%0d", k), cycles_left, k);
      check($sformatf("mul_stall_%0d", k), stall, 1);
      check($sformatf("mul_we_%0d", k), hilo_we, 0);
      step();
    end
    check("mul_done_we", hilo_we, 1);
    check("mul_done_stall", stall, 0);
    check("mul_done_busy", busy, 0);
    check("mul_done_cl", cycles_left, 0);
    check("mul_stall_cycles", stall_cycles, 6);
    step(); d_uses_mdu = 0; settle();
    check("mul_idle_we", hilo_we, 0);
    check("mul_idle_stall_cycles", stall_cycles, 6);

    // Reset in the middle of a mult
    start = 1; is_div = 0; step(); start = 0; step();
    check("rmid_cl_run2", cycles_left, 4);
    reset_n = 1'b0; d_uses_mdu = 1; settle();
    check("rmid_cl", cycles_left, 0);
    check("rmid_we", hilo_we, 0);
    check("rmid_stall_cycles", stall_cycles, 0);
    check("rmid_busy", busy, 0);
    check("rmid_stall", stall, 0);
    reset_n = 1'b1; d_uses_mdu = 0;
    we_seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (hilo_we) we_seen++;
    end
    check("rmid_no_we", we_seen, 0);

    // Div back-to-back
    start = 1; is_div = 1; step(); start = 0; is_div = 0; settle();
    for (int k = 10; k >= 1; k--) begin
      check($sformatf("div1_cl_%0d", k), cycles_left, k);
      step();
    end
    check("div1_we", hilo_we, 1);
    start = 1; is_div = 1; settle();
    check("div1_done_busy", busy, 1);
    step(); start = 0; is_div = 0; settle();
    check("div2_we_off", hilo_we, 0);
    for (int k = 10; k >= 1; k--) begin
      check($sformatf("div2_cl_%0d", k), cycles_left, k);
      step();
    end
    check("div2_we", hilo_we, 1);
    check("div_perr", protocol_err, 0);
    step();
    check("div_idle_we", hilo_we, 0);

    // Illegal restart during RUN cycle 3 of a mult
    start = 1; is_div = 0; step(); start = 0; settle();
    check("ill_cl1", cycles_left, 5);
    step(); check("ill_cl2", cycles_left, 4);
    step(); check("ill_cl3", cycles_left, 3);
    start = 1; is_div = 1; settle();
    check("ill_busy", busy, 1);
    step(); start = 0; is_div = 0; settle();
    check("ill_no_reload", cycles_left, 2);
    check("ill_perr", protocol_err, 1);
    step(); check("ill_cl5", cycles_left, 1);
    step(); check("ill_done_we", hilo_we, 1);
    step(); check("ill_perr_sticky", protocol_err, 1);
    check("ill_idle_we", hilo_we, 0);
    do_reset();
    check("ill_perr_cleared", protocol_err, 0);

    // Load-use merge with MDU idle
    for (int k = 0; k < 3; k++) begin
      load_use = 1; settle();
      check($sformatf("lu_pc_en_%0d", k), pc_en, 0);
      check($sformatf("lu_d_en_%0d", k), d_en, 0);
      check($sformatf("lu_flush_%0d", k), e_flush, 1);
      step();
    end
    load_use = 0; settle();
    check("lu_pc_en_off", pc_en, 1);
    check("lu_flush_off", e_flush, 0);
    check("lu_stall_cycles", stall_cycles, 3);

    // Overlapping load-use and MDU stall count once per cycle
    start = 1; d_uses_mdu = 1; load_use = 1; step(); start = 0;
    step(); step(); load_use = 0; step(); step(); step();
    check("ovl_we", hilo_we, 1);
    check("ovl_stall_cycles", stall_cycles, 9);
    d_uses_mdu = 0;
    do_reset();

    // Saturation of the stall counter
    load_use = 1;
    for (int k = 0; k < 100; k++) step();
    check("sat_100", stall_cycles, 100);
    for (int k = 100; k < 65540; k++) step();
    check("sat_max", stall_cycles, 16'hFFFF);
    step(); step();
    check("sat_hold", stall_cycles, 16'hFFFF);
    load_use = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
